axi3_burst_master: RTL and testbench

Testbench AXI3 burst initiator for the `axi_mem` utilities. It accepts single-burst commands on a simple valid/ready port and drives an `axi3_rd_if`/`axi3_wr_if` master pair. On reads it checks each beat against the identity pattern (address + 4·beat) and reports mismatches. On writes it generates data with that same pattern. It pairs with identity or memory slave models to exercise slave handshakes and burst lengths without a CPU.

---
 rtl/axi_mem_pkg.sv | 25 ++
 rtl/axi3_rd_if.sv | 33 +++
 rtl/axi3_wr_if.sv | 40 ++++
 rtl/axi3_burst_master.sv | 154 +++++++++++++++
 tb/tb_axi3_burst_master.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the axi_mem burst utilities.
// Master and slave models both compute the identity data pattern with identity_word().
package axi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } burst_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Wide enough for any supported address or data width; callers truncate.
    localparam int IDENT_W = 64;

    function automatic logic [IDENT_W-1:0] identity_word(input logic [IDENT_W-1:0] addr,
                                                         input logic [3:0]         beat);
        return addr + {{(IDENT_W-6){1'b0}}, beat, 2'b00};
    endfunction

endpackage

// File: rtl/axi3_rd_if.sv
// AXI3 read-side bundle (AR and R channels).
interface axi3_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [3:0]            arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [3:0]            rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi3_wr_if.sv
// AXI3 write-side bundle (AW, W and B channels).
interface axi3_wr_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [3:0]              awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;

    logic                    wvalid;
    logic                    wready;
    logic [3:0]              wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [3:0]              bid;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               wvalid, wid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               wvalid, wid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/axi3_burst_master.sv
// Single-burst AXI3 initiator: writes the identity pattern, checks it on reads,
// and keeps a saturating count of data and rlast errors.
module axi3_burst_master
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_len,
    output logic                  done,
    output logic                  err,
    output logic [ERR_WIDTH-1:0]  err_count,
    axi3_rd_if.master             rd,
    axi3_wr_if.master             wr
);

    burst_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [3:0]            beat_q;
    logic                  err_flag_q;
    logic [ERR_WIDTH-1:0]  err_count_q;

    logic                  cmd_accept;
    logic                  last_beat;
    logic                  r_beat;
    logic                  w_beat;
    logic                  mismatch;
    logic                  bad_last;
    logic [1:0]            err_inc;
    logic [ERR_WIDTH:0]    err_sum;
    logic [DATA_WIDTH-1:0] exp_word;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign last_beat  = (beat_q == len_q);
    assign exp_word   = DATA_WIDTH'(identity_word(IDENT_W'(addr_q), beat_q));

    assign r_beat   = (state_q == RD_DATA) && rd.rvalid;
    assign w_beat   = (state_q == WR_DATA) && wr.wready;
    assign mismatch = r_beat && (rd.rdata != exp_word);
    // Early rlast and missing final rlast both reduce to rlast disagreeing with last_beat.
    assign bad_last = r_beat && (rd.rlast != last_beat);
    assign err_inc  = {1'b0, mismatch} + {1'b0, bad_last};
    assign err_sum  = {1'b0, err_count_q} + (ERR_WIDTH+1)'(err_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd.arvalid = 1'b0;
        rd.rready  = 1'b0;
        wr.awvalid = 1'b0;
        wr.wvalid  = 1'b0;
        wr.wlast   = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = cmd_write ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                rd.arvalid = 1'b1;
                if (rd.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rd.rready = 1'b1;
                if (rd.rvalid && last_beat) state_d = DONE;
            end
            WR_ADDR: begin
                wr.awvalid = 1'b1;
                if (wr.awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                wr.wvalid = 1'b1;
                wr.wlast  = last_beat;
                if (wr.wready && last_beat) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (cmd_accept) begin
                addr_q     <= cmd_addr;
                len_q      <= cmd_len;
                beat_q     <= '0;
                err_flag_q <= 1'b0;
            end
            if (r_beat || w_beat) begin
                beat_q <= beat_q + 4'd1;
            end
            if (mismatch || bad_last) begin
                err_flag_q  <= 1'b1;
                err_count_q <= err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];
            end
        end
    end

    assign err       = (state_q == DONE) && err_flag_q;
    assign err_count = err_count_q;

    assign rd.arid    = '0;
    assign rd.araddr  = addr_q;
    assign rd.arlen   = len_q;
    assign rd.arsize  = AXI_SIZE_4B;
    assign rd.arburst = AXI_BURST_INCR;
    assign rd.arlock  = '0;
    assign rd.arcache = '0;
    assign rd.arprot  = '0;

    assign wr.awid    = '0;
    assign wr.awaddr  = addr_q;
    assign wr.awlen   = len_q;
    assign wr.awsize  = AXI_SIZE_4B;
    assign wr.awburst = AXI_BURST_INCR;
    assign wr.awlock  = '0;
    assign wr.awcache = '0;
    assign wr.awprot  = '0;
    assign wr.wid     = '0;
    assign wr.wdata   = exp_word;
    assign wr.wstrb   = '1;
    assign wr.bready  = 1'b1;

    // Response IDs/codes and the B channel are deliberately ignored by this master.
    logic unused_resp;
    assign unused_resp = ^{rd.rid, rd.rresp, wr.bvalid, wr.bid, wr.bresp};

endmodule

// File: tb/tb_axi3_burst_master.sv
// Directed bench for axi3_burst_master: a scripted AXI slave per burst plus a
// second instance with a 2-bit error counter for saturation.
module tb_axi3_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        done, err;
    logic [15:0] err_count;

    logic        sat_cmd_valid, sat_cmd_ready, sat_cmd_write;
    logic [31:0] sat_cmd_addr;
    logic [3:0]  sat_cmd_len;
    logic        sat_done, sat_err;
    logic [1:0]  sat_err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi3_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rd_bus ();
    axi3_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wr_bus ();
    axi3_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rd_sat ();
    axi3_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wr_sat ();

    axi3_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .done(done), .err(err), .err_count(err_count),
        .rd(rd_bus), .wr(wr_bus)
    );

    axi3_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .cmd_valid(sat_cmd_valid), .cmd_ready(sat_cmd_ready), .cmd_write(sat_cmd_write),
        .cmd_addr(sat_cmd_addr), .cmd_len(sat_cmd_len),
        .done(sat_done), .err(sat_err), .err_count(sat_err_count),
        .rd(rd_sat), .wr(wr_sat)
    );

    // Saturation slave: always answers with zero data and no rlast.
    assign rd_sat.arready = 1'b1;
    assign rd_sat.rvalid  = 1'b1;
    assign rd_sat.rdata   = 32'h0;
    assign rd_sat.rlast   = 1'b0;
    assign rd_sat.rid     = 4'h0;
    assign rd_sat.rresp   = 2'b00;
    assign wr_sat.awready = 1'b1;
    assign wr_sat.wready  = 1'b1;
    assign wr_sat.bvalid  = 1'b0;
    assign wr_sat.bid     = 4'h0;
    assign wr_sat.bresp   = 2'b00;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_rbeat(input logic [31:0] addr, input int beat, input int len,
                               input int bad_beat, input int early_last, input bit drop_last);
        logic [31:0] d;
        d = addr + 32'(4 * beat);
        if (beat == bad_beat) d = d ^ 32'h1;
        rd_bus.rvalid = 1'b1;
        rd_bus.rdata  = d;
        rd_bus.rlast  = ((beat == len) && !drop_last) || (beat == early_last);
    endtask

    task automatic run_read(input string tag, input logic [31:0] addr, input logic [3:0] len,
                            input int ar_stall, input int bad_beat, input int early_last,
                            input bit drop_last, input int exp_lat, input logic exp_err,
                            input logic [15:0] exp_cnt);
        int k, ar_cnt, beat, taken, lat;
        bit in_r, got_done, hs_ar, hs_r, av;
        logic err_at_done;
        logic [15:0] cnt_at_done;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
        check_val({tag, "_cmd_ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF; cmd_len = 4'hF;
        ar_cnt = ar_stall; rd_bus.arready = (ar_cnt == 0);
        k = 0; beat = 0; taken = 0; lat = 0; in_r = 0; got_done = 0;
        err_at_done = 1'b0; cnt_at_done = '0;
        while (!got_done && k < 100) begin
            @(negedge clk);
            if (done) begin
                got_done = 1; lat = k + 1; err_at_done = err; cnt_at_done = err_count;
            end else begin
                av    = rd_bus.arvalid;
                hs_ar = rd_bus.arvalid && rd_bus.arready;
                hs_r  = rd_bus.rvalid && rd_bus.rready;
                if (hs_ar) begin
                    check_val({tag, "_araddr"}, rd_bus.araddr, addr);
                    check_val({tag, "_arlen"}, rd_bus.arlen, len);
                    check_val({tag, "_arsize"}, rd_bus.arsize, 3'd2);
                    check_val({tag, "_arburst"}, rd_bus.arburst, 2'b01);
                end
                @(posedge clk); k++; #1;
                if (!in_r) begin
                    if (hs_ar) begin
                        in_r = 1; rd_bus.arready = 1'b0;
                        drive_rbeat(addr, 0, int'(len), bad_beat, early_last, drop_last);
                    end else if (av && ar_cnt > 0) begin
                        ar_cnt--; rd_bus.arready = (ar_cnt == 0);
                    end
                end else if (hs_r) begin
                    taken++; beat++;
                    if (beat > int'(len)) begin
                        rd_bus.rvalid = 1'b0; rd_bus.rlast = 1'b0;
                    end else begin
                        drive_rbeat(addr, beat, int'(len), bad_beat, early_last, drop_last);
                    end
                end
            end
        end
        check_val({tag, "_done_seen"}, got_done, 1);
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_beats"}, taken, int'(len) + 1);
        check_val({tag, "_err"}, err_at_done, exp_err);
        check_val({tag, "_err_count"}, cnt_at_done, exp_cnt);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 0);
        check_val({tag, "_ready_again"}, cmd_ready, 1);
        check_val({tag, "_rready_idle"}, rd_bus.rready, 0);
        rd_bus.rvalid = 1'b0; rd_bus.rlast = 1'b0;
    endtask

    task automatic run_write(input string tag, input logic [31:0] addr, input logic [3:0] len,
                             input int exp_lat);
        int k, beat, lat;
        bit got_done;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_len = 4'h0;
        k = 0; beat = 0; lat = 0; got_done = 0;
        while (!got_done && k < 100) begin
            @(negedge clk);
            if (done) begin
                got_done = 1; lat = k + 1;
                check_val({tag, "_err"}, err, 0);
            end else begin
                if (wr_bus.awvalid && wr_bus.awready) begin
                    check_val({tag, "_awaddr"}, wr_bus.awaddr, addr);
                    check_val({tag, "_awlen"}, wr_bus.awlen, len);
                    check_val({tag, "_awsize"}, wr_bus.awsize, 3'd2);
                    check_val({tag, "_awburst"}, wr_bus.awburst, 2'b01);
                end
                if (wr_bus.wvalid && wr_bus.wready) begin
                    check_val({tag, "_wdata"}, wr_bus.wdata, addr + 32'(4 * beat));
                    check_val({tag, "_wlast"}, wr_bus.wlast, beat == int'(len));
                    check_val({tag, "_wstrb"}, wr_bus.wstrb, 4'hF);
                    beat++;
                end
                @(posedge clk); k++;
            end
        end
        check_val({tag, "_done_seen"}, got_done, 1);
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_beats"}, beat, int'(len) + 1);
        @(negedge clk);
        check_val({tag, "_ready_again"}, cmd_ready, 1);
    endtask

    task automatic run_sat(input string tag, input logic [1:0] exp_cnt);
        int k;
        bit got_done;
        @(negedge clk);
        sat_cmd_valid = 1'b1; sat_cmd_write = 1'b0; sat_cmd_addr = 32'h10; sat_cmd_len = 4'd0;
        @(posedge clk); #1;
        sat_cmd_valid = 1'b0;
        k = 0; got_done = 0;
        while (!got_done && k < 50) begin
            @(negedge clk);
            if (sat_done) begin
                got_done = 1;
                check_val({tag, "_err"}, sat_err, 1);
                check_val({tag, "_err_count"}, sat_err_count, exp_cnt);
            end else begin
                @(posedge clk); k++;
            end
        end
        check_val({tag, "_done_seen"}, got_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        sat_cmd_valid = 1'b0; sat_cmd_write = 1'b0; sat_cmd_addr = '0; sat_cmd_len = '0;
        rd_bus.arready = 1'b0; rd_bus.rvalid = 1'b0; rd_bus.rdata = '0;
        rd_bus.rlast = 1'b0; rd_bus.rid = '0; rd_bus.rresp = '0;
        wr_bus.awready = 1'b1; wr_bus.wready = 1'b1;
        wr_bus.bvalid = 1'b0; wr_bus.bid = '0; wr_bus.bresp = '0;
        #2;
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_arvalid", rd_bus.arvalid, 0);
        check_val("rst_awvalid", wr_bus.awvalid, 0);
        check_val("rst_wvalid", wr_bus.wvalid, 0);
        check_val("rst_rready", rd_bus.rready, 0);
        check_val("rst_wlast", wr_bus.wlast, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_err_count", err_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_cmd_ready", cmd_ready, 1);

        //        tag       addr          len stall bad  early drop lat err cnt
        run_read("rd_l3",  32'h1000_0000, 4'd3, 0, -1, -1, 0,  6, 1'b0, 16'd0);
        run_write("wr_l7", 32'h0000_0100, 4'd7, 10);
        run_read("rd_l0w", 32'hFFFF_FFFC, 4'd0, 0, -1, -1, 0,  3, 1'b0, 16'd0);
        run_read("rd_l1w", 32'hFFFF_FFFC, 4'd1, 0, -1, -1, 0,  4, 1'b0, 16'd0);
        run_read("rd_bad", 32'h1000_0000, 4'd3, 3,  2, -1, 0,  9, 1'b1, 16'd1);
        run_read("rd_erl", 32'h0000_2000, 4'd3, 0, -1,  1, 0,  6, 1'b1, 16'd2);
        run_read("rd_dbl", 32'h0000_3000, 4'd3, 0,  3, -1, 1,  6, 1'b1, 16'd4);
        run_read("rd_nol", 32'h0000_0040, 4'd2, 0, -1, -1, 1,  5, 1'b1, 16'd5);

        // Reset while the master is presenting write beat 2.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0200; cmd_len = 4'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rstmid_wvalid_before", wr_bus.wvalid, 1);
        check_val("rstmid_wdata_before", wr_bus.wdata, 32'h0000_0208);
        rst = 1'b1;
        #1;
        check_val("rstmid_wvalid", wr_bus.wvalid, 0);
        check_val("rstmid_awvalid", wr_bus.awvalid, 0);
        check_val("rstmid_cmd_ready", cmd_ready, 0);
        check_val("rstmid_err_count", err_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rstmid_no_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("rstmid_ready_after", cmd_ready, 1);
        check_val("rstmid_done_after", done, 0);
        check_val("rstmid_err_count_after", err_count, 0);

        run_read("rd_l15", 32'h0000_0080, 4'd15, 0, -1, -1, 0, 18, 1'b0, 16'd0);

        run_sat("sat1", 2'd2);
        run_sat("sat2", 2'd3);
        run_sat("sat3", 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
